// File: rtl/serial_frame_tx.sv
// serial_frame_tx: double-buffered parallel-to-serial frame transmitter.
// Frame = start 0, DATA_WIDTH data bits, stop 1; each bit CLKS_PER_BIT clocks.
module serial_frame_tx #(
  parameter int DATA_WIDTH   = 16,
  parameter int CLKS_PER_BIT = 4,
  parameter int MSB_FIRST    = 1
) (
  input  logic                  CLOCK_50,
  input  logic                  Reset,
  input  logic [DATA_WIDTH-1:0] Parallel_Data,
  input  logic                  Load_Valid,
  output logic                  Load_Ready,
  output logic                  Serial_Out,
  output logic                  Busy,
  output logic                  Frame_Done
);

  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam int NW = $clog2(DATA_WIDTH) + 1;
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [NW-1:0] DATA_LAST = NW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] hold_reg;
  logic                  hold_full;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [CW-1:0]         bit_cnt;
  logic [NW-1:0]         data_cnt;
  logic                  serial_q;
  logic                  busy_q;
  logic                  done_q;

  function automatic logic out_bit(
    input logic [DATA_WIDTH-1:0] v
  );
    return (MSB_FIRST != 0) ? v[DATA_WIDTH-1] : v[0];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] shifted(
    input logic [DATA_WIDTH-1:0] v
  );
    return (MSB_FIRST != 0) ? (v << 1) : (v >> 1);
  endfunction

  assign Load_Ready = ~hold_full;
  assign Serial_Out = serial_q;
  assign Busy       = busy_q;
  assign Frame_Done = done_q;

  // Holding-register handshake plus the framing FSM with registered outputs.
  always_ff @(posedge CLOCK_50 or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      hold_reg  <= '0;
      hold_full <= 1'b0;
      shift_reg <= '0;
      bit_cnt   <= '0;
      data_cnt  <= '0;
      serial_q  <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;

      if (Load_Valid && !hold_full) begin
        hold_reg  <= Parallel_Data;
        hold_full <= 1'b1;
      end

      unique case (state)
        IDLE: begin
          if (hold_full) begin
            state     <= START;
            shift_reg <= hold_reg;
            hold_full <= 1'b0;
            bit_cnt   <= '0;
            serial_q  <= 1'b0;
            busy_q    <= 1'b1;
          end
        end
        START: begin
          if (bit_cnt == BIT_LAST) begin
            state     <= DATA;
            bit_cnt   <= '0;
            data_cnt  <= '0;
            serial_q  <= out_bit(shift_reg);
            shift_reg <= shifted(shift_reg);
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_cnt == BIT_LAST) begin
            bit_cnt <= '0;
            if (data_cnt == DATA_LAST) begin
              state    <= STOP;
              serial_q <= 1'b1;
            end else begin
              data_cnt  <= data_cnt + 1'b1;
              serial_q  <= out_bit(shift_reg);
              shift_reg <= shifted(shift_reg);
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        STOP: begin
          if (bit_cnt == BIT_LAST) begin
            done_q  <= 1'b1;
            bit_cnt <= '0;
            if (hold_full) begin
              // Buffered word: chain straight into the next start bit.
              state     <= START;
              shift_reg <= hold_reg;
              hold_full <= 1'b0;
              serial_q  <= 1'b0;
            end else begin
              state  <= IDLE;
              busy_q <= 1'b0;
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_frame_tx.sv
// tb_serial_frame_tx: directed checks of serial_frame_tx framing,
// double-buffering, reset abort and single-cycle bit timing.
module tb_serial_frame_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [7:0]  pd;
  logic        lv;
  logic        a_ready, a_ser, a_busy, a_fd;
  logic        b_ready, b_ser, b_busy, b_fd;
  logic [15:0] pd_c;
  logic        lv_c;
  logic        c_ready, c_ser, c_busy, c_fd;

  int checks   = 0;
  int failures = 0;

  serial_frame_tx #(
    .DATA_WIDTH(8), .CLKS_PER_BIT(2), .MSB_FIRST(1)
  ) dut_a (
    .CLOCK_50(clk), .Reset(rst),
    .Parallel_Data(pd), .Load_Valid(lv),
    .Load_Ready(a_ready), .Serial_Out(a_ser),
    .Busy(a_busy), .Frame_Done(a_fd)
  );

  serial_frame_tx #(
    .DATA_WIDTH(8), .CLKS_PER_BIT(2), .MSB_FIRST(0)
  ) dut_b (
    .CLOCK_50(clk), .Reset(rst),
    .Parallel_Data(pd), .Load_Valid(lv),
    .Load_Ready(b_ready), .Serial_Out(b_ser),
    .Busy(b_busy), .Frame_Done(b_fd)
  );

  serial_frame_tx #(
    .DATA_WIDTH(16), .CLKS_PER_BIT(1), .MSB_FIRST(1)
  ) dut_c (
    .CLOCK_50(clk), .Reset(rst),
    .Parallel_Data(pd_c), .Load_Valid(lv_c),
    .Load_Ready(c_ready), .Serial_Out(c_ser),
    .Busy(c_busy), .Frame_Done(c_fd)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One 20-cycle frame on dut_a (and optionally dut_b), sampled at negedges.
  task automatic frame_a(
    input string      tag,
    input logic [9:0] ea,
    input logic [9:0] eb,
    input bit         chk_b,
    input bit         fd0,
    input bit         chaos
  );
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk({tag, "_ser"}, a_ser, ea[9-k/2]);
      if (chk_b) chk({tag, "_ser_b"}, b_ser, eb[9-k/2]);
      chk({tag, "_fd"}, a_fd, (k == 0 && fd0));
      chk({tag, "_busy"}, a_busy, 1);
      chk({tag, "_ready"}, a_ready, chaos ? (k == 0) : 1'b1);
      if (chaos && k >= 1) begin
        pd = 8'($urandom);
        lv = (k < 19);
      end
    end
  endtask

  initial begin
    logic [17:0] exp_c;
    exp_c = 18'b01_0000_0000_0000_0011;
    rst  = 1'b1;
    pd   = 8'h00;
    lv   = 1'b0;
    pd_c = 16'h0000;
    lv_c = 1'b0;

    @(posedge clk);
    @(negedge clk);
    chk("rst_ser", a_ser, 1);
    chk("rst_busy", a_busy, 0);
    chk("rst_ready", a_ready, 1);
    chk("rst_fd", a_fd, 0);
    chk("rst_ser_c", c_ser, 1);

    rst = 1'b0;
    pd  = 8'h41;
    lv  = 1'b1;
    @(negedge clk);
    chk("acc_ready", a_ready, 0);
    chk("acc_ser", a_ser, 1);
    chk("acc_busy", a_busy, 0);
    lv = 1'b0;
    pd = 8'hFF;
    frame_a("f41", 10'b0010000011, 10'b0100000101, 1, 0, 0);
    @(negedge clk);
    chk("f41_end_fd", a_fd, 1);
    chk("f41_end_fd_b", b_fd, 1);
    chk("f41_end_busy", a_busy, 0);
    chk("f41_end_ser", a_ser, 1);
    @(negedge clk);
    chk("f41_fd_off", a_fd, 0);

    pd = 8'hA5;
    lv = 1'b1;
    @(negedge clk);
    chk("a5_acc_ready", a_ready, 0);
    pd = 8'h3C;
    frame_a("fa5", 10'b0101001011, 10'b0, 0, 0, 1);
    frame_a("f3c", 10'b0001111001, 10'b0, 0, 1, 0);
    @(negedge clk);
    chk("f3c_end_fd", a_fd, 1);
    chk("f3c_end_busy", a_busy, 0);
    chk("f3c_end_ser", a_ser, 1);
    chk("f3c_end_ready", a_ready, 1);

    pd = 8'h41;
    lv = 1'b1;
    @(negedge clk);
    lv = 1'b0;
    for (int k = 0; k <= 8; k++) begin
      @(negedge clk);
      if (k == 0) begin
        pd = 8'h99;
        lv = 1'b1;
      end
      if (k == 1) lv = 1'b0;
    end
    chk("pre_rst_ser", a_ser, 0);
    chk("pre_rst_ready", a_ready, 0);
    chk("pre_rst_busy", a_busy, 1);
    rst = 1'b1;
    #1;
    chk("arst_ser", a_ser, 1);
    chk("arst_busy", a_busy, 0);
    chk("arst_ready", a_ready, 1);
    chk("arst_fd", a_fd, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      chk("post_rst_fd", a_fd, 0);
      chk("post_rst_ser", a_ser, 1);
      chk("post_rst_busy", a_busy, 0);
    end

    pd_c = 16'h8001;
    lv_c = 1'b1;
    @(negedge clk);
    chk("c_acc_ready", c_ready, 0);
    chk("c_acc_ser", c_ser, 1);
    lv_c = 1'b0;
    pd_c = 16'hFFFF;
    for (int k = 0; k < 18; k++) begin
      @(negedge clk);
      chk("c_ser", c_ser, exp_c[17-k]);
      chk("c_busy", c_busy, 1);
      chk("c_fd", c_fd, 0);
    end
    @(negedge clk);
    chk("c_end_fd", c_fd, 1);
    chk("c_end_ser", c_ser, 1);
    chk("c_end_busy", c_busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
